// File: rtl/gpio_input_port_pkg.sv
// rtl/gpio_input_port_pkg.sv - register offsets, load/store funct3 codes and base address shared by the GPIO input port
package gpio_input_port_pkg;

  localparam logic [31:0] GPIO_BASE_ADDR = 32'hFFFF_0100;

  typedef enum logic [2:0] {
    GPIO_LEVEL    = 3'd0,
    GPIO_RISE     = 3'd1,
    GPIO_FALL     = 3'd2,
    GPIO_DEBOUNCE = 3'd3,
    GPIO_IRQ_MASK = 3'd4
  } gpio_reg_offset_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_t;

  // Picks the byte/half the core asked for and extends it the way the load instruction expects.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] byte_off);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {byte_off, 3'b000};
    b = shifted[7:0];
    h = byte_off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   load_extract = {{24{b[7]}}, b};
      F3_LBU:  load_extract = {24'h0, b};
      F3_LH:   load_extract = {{16{h[15]}}, h};
      F3_LHU:  load_extract = {16'h0, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/gpio_input_port_input_debouncer.sv
// rtl/gpio_input_port_input_debouncer.sv - one-bit synchroniser plus debounce state machine with edge pulses
module gpio_input_port_input_debouncer
  import gpio_input_port_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic [CNT_W-1:0] debounce,
  output logic             stable,
  output logic             rise,
  output logic             fall
);

  logic             meta_q, sync_q;
  logic             stable_q, stable_d;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      state_q  <= DB_STABLE;
      cnt_q    <= '0;
    end else begin
      meta_q   <= din;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise     = 1'b0;
    fall     = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (sync_q != stable_q) begin
          state_d = DB_COUNTING;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_COUNTING: begin
        // The live debounce value is compared, so a rewrite mid-count applies at once.
        if (sync_q == stable_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= debounce) begin
          stable_d = sync_q;
          state_d  = DB_STABLE;
          cnt_d    = '0;
          rise     = sync_q;
          fall     = ~sync_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = DB_STABLE;
    endcase
  end

  assign stable = stable_q;

endmodule

// File: rtl/gpio_input_port.sv
// rtl/gpio_input_port.sv - memory-mapped debounced GPIO inputs with RISE/FALL edge latches
// Define GPIO_INPUT_PORT_IRQ_EN to add the IRQ_MASK register and the irq output.
module gpio_input_port
  import gpio_input_port_pkg::*;
#(
  parameter int               N_INPUTS       = 4,
  parameter logic [31:0]      BASE_ADDR      = GPIO_BASE_ADDR,
  parameter int               CNT_W          = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_RESET = 16'd12000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_INPUTS-1:0] gpio_in,
  input  logic                write_mem,
  input  logic [2:0]          funct3,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                hit,
  output logic                irq
);

  logic [N_INPUTS-1:0] level, rise_set, fall_set, wr_bits;
  logic [N_INPUTS-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0]    debounce_q, debounce_d;
  logic [31:0]         read_data_q, read_data_d, reg_word;
  logic                hit_q, sel, wr_en;
  logic                unused_wdata;

`ifdef GPIO_INPUT_PORT_IRQ_EN
  logic [N_INPUTS-1:0] irq_mask_q, irq_mask_d;
  logic                irq_q;
`endif

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_in
    gpio_input_port_input_debouncer #(.CNT_W(CNT_W)) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .din      (gpio_in[i]),
      .debounce (debounce_q),
      .stable   (level[i]),
      .rise     (rise_set[i]),
      .fall     (fall_set[i])
    );
  end

  assign sel          = address[31:5] == BASE_ADDR[31:5];
  assign wr_en        = write_mem && sel && (funct3 == F3_LW) && (address[1:0] == 2'b00);
  assign wr_bits      = write_data[N_INPUTS-1:0];
  assign unused_wdata = ^write_data;

  // Edge set is OR-ed in after the W1C mask so a coincident new edge survives the clear.
  always_comb begin
    rise_d     = rise_q | rise_set;
    fall_d     = fall_q | fall_set;
    debounce_d = debounce_q;
    if (wr_en) begin
      case (address[4:2])
        GPIO_RISE:     rise_d     = (rise_q & ~wr_bits) | rise_set;
        GPIO_FALL:     fall_d     = (fall_q & ~wr_bits) | fall_set;
        GPIO_DEBOUNCE: debounce_d = write_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_word = '0;
    case (address[4:2])
      GPIO_LEVEL:    reg_word = 32'(level);
      GPIO_RISE:     reg_word = 32'(rise_q);
      GPIO_FALL:     reg_word = 32'(fall_q);
      GPIO_DEBOUNCE: reg_word = 32'(debounce_q);
      GPIO_IRQ_MASK: begin
`ifdef GPIO_INPUT_PORT_IRQ_EN
        reg_word = 32'(irq_mask_q);
`endif
      end
      default: ;
    endcase
    read_data_d = sel ? load_extract(reg_word, funct3, address[1:0]) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q      <= '0;
      fall_q      <= '0;
      debounce_q  <= DEBOUNCE_RESET;
      read_data_q <= '0;
      hit_q       <= 1'b0;
    end else begin
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      debounce_q  <= debounce_d;
      read_data_q <= read_data_d;
      hit_q       <= sel;
    end
  end

`ifdef GPIO_INPUT_PORT_IRQ_EN
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && (address[4:2] == GPIO_IRQ_MASK)) irq_mask_d = wr_bits;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= |((rise_q | fall_q) & irq_mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign read_data = read_data_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_gpio_input_port.sv
// tb/tb_gpio_input_port.sv - randomized self-checking bench for gpio_input_port against a run-length reference model
module tb_gpio_input_port;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0100;
`ifdef GPIO_INPUT_PORT_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          write_mem = 1'b0;
  logic [N-1:0]  gpio_in = '1;
  logic [2:0]    funct3 = 3'b010;
  logic [31:0]   address = 32'h0;
  logic [31:0]   write_data = 32'h0;
  logic [31:0]   read_data;
  logic          hit, irq;

  int            n_tests = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;
  logic [31:0]   last_rd;

  logic [N-1:0]  m_s1 = '0, m_s2 = '0, m_level = '0, m_rise = '0, m_fall = '0, m_mask = '0;
  logic [15:0]   m_deb = 16'd12000;
  logic          m_irq = 1'b0;
  int            m_run[N];

  gpio_input_port #(
    .N_INPUTS(N), .BASE_ADDR(BASE), .CNT_W(16), .DEBOUNCE_RESET(16'd12000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .gpio_in(gpio_in), .write_mem(write_mem),
    .funct3(funct3), .address(address), .write_data(write_data),
    .read_data(read_data), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd32);
  endfunction

  // An input's level follows the synchronised pin once it has disagreed for max(DEBOUNCE+1, 2) edges in a row.
  always @(posedge clk or negedge reset_n) begin : model
    logic [N-1:0] sr, sf, cr, cf;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_mask = '0;
      m_deb = 16'd12000; m_irq = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      m_irq = |((m_rise | m_fall) & m_mask);
      sr = '0; sf = '0; cr = '0; cf = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= 2 && m_run[i] - 1 >= int'(m_deb)) begin
            m_level[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i]) sr[i] = 1'b1; else sf[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (write_mem && in_win(address) && funct3 == 3'b010 && address[1:0] == 2'b00) begin
        case ((address - BASE) / 32'd4)
          32'd1: cr = write_data[N-1:0];
          32'd2: cf = write_data[N-1:0];
          32'd3: m_deb = write_data[15:0];
          32'd4: if (IRQ_EN) m_mask = write_data[N-1:0];
          default: ;
        endcase
      end
      m_rise = (m_rise & ~cr) | sr;
      m_fall = (m_fall & ~cf) | sf;
      m_s2 = m_s1;
      m_s1 = gpio_in;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w, b, h;
    if (!in_win(a)) return 32'h0;
    case ((a - BASE) / 32'd4)
      32'd0:   w = 32'(m_level);
      32'd1:   w = 32'(m_rise);
      32'd2:   w = 32'(m_fall);
      32'd3:   w = 32'(m_deb);
      32'd4:   w = IRQ_EN ? 32'(m_mask) : 32'h0;
      default: w = 32'h0;
    endcase
    b = (w >> (32'd8 * (a % 32'd4))) & 32'hFF;
    h = (w >> (32'd16 * ((a % 32'd4) / 32'd2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) if (mon_en) check("irq", 32'(irq), 32'(m_irq));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [2:0] f3, input string tag);
    logic [31:0] exp_d;
    logic        exp_h;
    @(negedge clk);
    write_mem = 1'b0; address = a; funct3 = f3;
    exp_d = model_read(a, f3);
    exp_h = in_win(a);
    @(posedge clk);
    #1;
    check({tag, "_data"}, read_data, exp_d);
    check({tag, "_hit"}, 32'(hit), 32'(exp_h));
    last_rd = read_data;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    write_mem = 1'b1; address = a; write_data = d; funct3 = f3;
    @(posedge clk);
    #1;
    write_mem = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  f;
    int          off;

    tick(3);
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_rdata", read_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    bus_read(BASE + 32'h0, 3'b010, "rst_level"); check("rst_level_k", last_rd, 32'h0);
    bus_read(BASE + 32'h4, 3'b010, "rst_rise");  check("rst_rise_k", last_rd, 32'h0);
    bus_read(BASE + 32'h8, 3'b010, "rst_fall");  check("rst_fall_k", last_rd, 32'h0);
    bus_read(BASE + 32'hC, 3'b010, "rst_deb");   check("rst_deb_k", last_rd, 32'd12000);

    gpio_in = '0;
    bus_write(BASE + 32'hC, 32'd5, 3'b010);
    tick(20);
    bus_read(BASE + 32'hC, 3'b010, "deb5");

    // Level must appear on the read sampled at the ninth edge after the pin moves.
    gpio_in[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      bus_read(BASE, 3'b010, "lat");
      check("lat_bit0", 32'(last_rd[0]), (i >= 9) ? 32'h1 : 32'h0);
    end
    bus_read(BASE + 32'h4, 3'b010, "rise0"); check("rise0_k", last_rd, 32'h1);

    gpio_in[1] = 1'b1; tick(3); gpio_in[1] = 1'b0; tick(20);
    bus_read(BASE, 3'b010, "glitch_level"); check("glitch_level_k", last_rd, 32'h1);
    bus_read(BASE + 32'h4, 3'b010, "glitch_rise"); check("glitch_rise_k", last_rd, 32'h1);

    gpio_in[1] = 1'b1; tick(15);
    bus_read(BASE + 32'h4, 3'b010, "rise3"); check("rise3_k", last_rd, 32'h3);
    bus_write(BASE + 32'h4, 32'h1, 3'b010);
    bus_read(BASE + 32'h4, 3'b010, "w1c"); check("w1c_k", last_rd, 32'h2);

    gpio_in[0] = 1'b0; tick(15);
    gpio_in[0] = 1'b1; tick(7);
    bus_write(BASE + 32'h4, 32'h1, 3'b010);
    bus_read(BASE + 32'h4, 3'b010, "setwins"); check("setwins_k", last_rd, 32'h3);

    gpio_in = 8'h80; tick(20);
    bus_read(BASE, 3'b000, "lb");   check("lb_k", last_rd, 32'hFFFF_FF80);
    bus_read(BASE, 3'b100, "lbu");  check("lbu_k", last_rd, 32'h0000_0080);
    bus_read(BASE, 3'b001, "lh");
    bus_read(BASE + 32'h1, 3'b000, "lb1");
    bus_read(BASE + 32'hC, 3'b100, "lbu_deb");
    bus_write(BASE + 32'hC, 32'h33, 3'b000);
    bus_write(BASE + 32'hE, 32'h33, 3'b010);
    bus_write(BASE + 32'hC, 32'h33, 3'b001);
    bus_read(BASE + 32'hC, 3'b010, "sb_deb"); check("sb_deb_k", last_rd, 32'd5);
    bus_read(BASE + 32'h20, 3'b010, "oow");
    check("oow_data_k", last_rd, 32'h0);
    check("oow_hit_k", 32'(hit), 32'h0);

    gpio_in = 8'h84; tick(20);
    bus_write(BASE + 32'h4, 32'hFF, 3'b010);
    bus_write(BASE + 32'h8, 32'hFF, 3'b010);
    bus_write(BASE + 32'h10, 32'h4, 3'b010);
    bus_read(BASE + 32'h10, 3'b010, "mask");
    gpio_in = 8'h80; tick(20);
    check("irq_fall2", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
    bus_write(BASE + 32'h8, 32'h4, 3'b010);
    check("irq_hold", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
    tick(1);
    check("irq_clr", 32'(irq), 32'h0);
    gpio_in = 8'h81; tick(20);
    check("irq_masked", 32'(irq), 32'h0);

    bus_write(BASE + 32'hC, 32'd3, 3'b010);
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          gpio_in = gpio_in ^ N'($urandom_range(1, 255));
          tick($urandom_range(1, 12));
        end
        1, 2: begin
          a = BASE + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
          if ($urandom_range(0, 9) == 0) a = a + 32'h20;
          bus_read(a, 3'($urandom_range(0, 7)), "rnd_rd");
        end
        3: begin
          off = $urandom_range(0, 5);
          a = BASE + 32'(off) * 32'd4;
          f = 3'b010;
          if ($urandom_range(0, 5) == 0) begin
            a = a + 32'($urandom_range(0, 3));
            f = 3'($urandom_range(0, 7));
          end
          d = (off == 3) ? 32'($urandom_range(0, 8)) : $urandom;
          bus_write(a, d, f);
        end
        default: tick($urandom_range(1, 6));
      endcase
    end

    gpio_in = '0; tick(30);
    bus_write(BASE + 32'hC, 32'd100, 3'b010);
    bus_write(BASE + 32'h4, 32'hFF, 3'b010);
    bus_write(BASE + 32'h8, 32'hFF, 3'b010);
    gpio_in = 8'h01; tick(52);
    reset_n = 1'b0; tick(2);
    reset_n = 1'b1;
    bus_read(BASE, 3'b010, "mid_level"); check("mid_level_k", last_rd, 32'h0);
    bus_read(BASE + 32'h4, 3'b010, "mid_rise"); check("mid_rise_k", last_rd, 32'h0);
    bus_write(BASE + 32'hC, 32'd100, 3'b010);
    tick(60);
    bus_read(BASE, 3'b010, "fresh_lo"); check("fresh_lo_k", last_rd, 32'h0);
    tick(60);
    bus_read(BASE, 3'b010, "fresh_hi"); check("fresh_hi_k", last_rd, 32'h1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
